// File: rtl/ysyx_24100005_rf_pkg.sv
// Shared widths, zero-register index and payload types for the integer register file.
package ysyx_24100005_rf_pkg;

  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_ZERO_IDX = 0;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/ysyx_24100005_rf_cell.sv
// One register-file entry: a WIDTH-bit register with load enable and async active-low clear.
module ysyx_24100005_rf_cell #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (wen) data_d = din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= RESET_VAL;
    else      data_q <= data_d;
  end

  assign dout = data_q;

endmodule

// File: rtl/ysyx_24100005_register_file.sv
// 2R1W integer register file with x0 hardwired to zero.
// Define YSYX_RF_BYPASS_EN to forward same-cycle write data onto matching read ports.
module ysyx_24100005_register_file
  import ysyx_24100005_rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_W,
  parameter int unsigned DATA_WIDTH = RF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] rs1addr,
  input  logic [ADDR_WIDTH-1:0] rs2addr,
  output logic [DATA_WIDTH-1:0] rs1data,
  output logic [DATA_WIDTH-1:0] rs2data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(RF_ZERO_IDX);

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  assign regs[0] = '0;

  // Entries 1..DEPTH-1 each load only when addressed.
  for (genvar i = 1; i < DEPTH; i++) begin : g_cell
    logic cell_wen;
    assign cell_wen = wen && (waddr == ADDR_WIDTH'(i));
    ysyx_24100005_rf_cell #(
      .WIDTH     (DATA_WIDTH),
      .RESET_VAL ('0)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .din  (wdata),
      .wen  (cell_wen),
      .dout (regs[i])
    );
  end

`ifdef YSYX_RF_BYPASS_EN
  logic wr_live;
  assign wr_live = wen && rst && (waddr != ZERO_IDX);
`endif

  always_comb begin
    rs1data = '0;
    rs2data = '0;
    if (rs1addr != ZERO_IDX) rs1data = regs[rs1addr];
    if (rs2addr != ZERO_IDX) rs2data = regs[rs2addr];
`ifdef YSYX_RF_BYPASS_EN
    if (wr_live && (rs1addr == waddr)) rs1data = wdata;
    if (wr_live && (rs2addr == waddr)) rs2data = wdata;
`endif
  end

endmodule

// File: tb/tb_ysyx_24100005_register_file.sv
// Directed vector bench for ysyx_24100005_register_file (default and YSYX_RF_BYPASS_EN builds).
module tb_ysyx_24100005_register_file;

  logic        clk;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  rs1addr;
  logic [4:0]  rs2addr;
  logic [31:0] rs1data;
  logic [31:0] rs2data;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_24100005_register_file #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .wen     (wen),
    .waddr   (waddr),
    .wdata   (wdata),
    .rs1addr (rs1addr),
    .rs2addr (rs2addr),
    .rs1data (rs1data),
    .rs2data (rs2data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{"wr_x1",      1'b1, 5'd1,  32'h12345678, 5'd1,  5'd0,  32'h12345678, 32'h0};
    vecs[1] = '{"wr_x31",     1'b1, 5'd31, 32'h80000000, 5'd1,  5'd31, 32'h12345678, 32'h80000000};
    vecs[2] = '{"wr_x0",      1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3] = '{"wr_x7",      1'b1, 5'd7,  32'h0000000A, 5'd7,  5'd1,  32'h0000000A, 32'h12345678};
    vecs[4] = '{"wen_gate",   1'b0, 5'd7,  32'h00000055, 5'd7,  5'd7,  32'h0000000A, 32'h0000000A};
    vecs[5] = '{"wr_x3",      1'b1, 5'd3,  32'h00000011, 5'd3,  5'd31, 32'h00000011, 32'h80000000};
    vecs[6] = '{"wr_x9",      1'b1, 5'd9,  32'hCAFEBABE, 5'd9,  5'd9,  32'hCAFEBABE, 32'hCAFEBABE};
    vecs[7] = '{"wr_x2",      1'b1, 5'd2,  32'hA5A5A5A5, 5'd2,  5'd3,  32'hA5A5A5A5, 32'h00000011};
    vecs[8] = '{"idle_read",  1'b0, 5'd2,  32'h00000000, 5'd31, 5'd0,  32'h80000000, 32'h0};
    vecs[9] = '{"ovr_x31",    1'b1, 5'd31, 32'h00000000, 5'd31, 5'd1,  32'h0,        32'h12345678};

    // Reset held two cycles while a write is attempted.
    rst = 1'b0; wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    rs1addr = 5'd5; rs2addr = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_rs1", rs1data, 32'h0);
    check("rst_hold_rs2", rs2data, 32'h0);
    @(negedge clk);
    wen = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_rel_x5", rs1data, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rs1addr = 5'(i);
      rs2addr = 5'(31 - i);
      #1;
      check($sformatf("rst_sweep_rs1_%0d", i), rs1data, 32'h0);
      check($sformatf("rst_sweep_rs2_%0d", 31 - i), rs2data, 32'h0);
    end

    // Table-driven write/read vectors, checked just after the edge.
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      wen = vecs[v].wen; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
      rs1addr = vecs[v].r1; rs2addr = vecs[v].r2;
      @(posedge clk); #1;
      check({vecs[v].name, "_rs1"}, rs1data, vecs[v].exp1);
      check({vecs[v].name, "_rs2"}, rs2data, vecs[v].exp2);
    end

    // Read-during-write on x3 (holds 0x11).
    @(negedge clk);
    wen = 1'b1; waddr = 5'd3; wdata = 32'h00000022; rs1addr = 5'd3; rs2addr = 5'd0;
    #1;
`ifdef YSYX_RF_BYPASS_EN
    check("rdw_pre_edge", rs1data, 32'h00000022);
`else
    check("rdw_pre_edge", rs1data, 32'h00000011);
`endif
    check("rdw_pre_x0", rs2data, 32'h0);
    @(posedge clk); #1;
    check("rdw_post_edge", rs1data, 32'h00000022);

    // Async reset dropped between edges clears x9 without a clock.
    @(negedge clk);
    wen = 1'b0; rs2addr = 5'd9; rs1addr = 5'd3;
    #1;
    check("pre_async_x9", rs2data, 32'hCAFEBABE);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_x9", rs2data, 32'h0);
    check("async_rst_x3", rs1data, 32'h0);

    // Write presented across an edge while reset is low is lost.
    wen = 1'b1; waddr = 5'd4; wdata = 32'h13579BDF; rs1addr = 5'd4;
    @(posedge clk); #1;
    check("rst_vs_write_x4", rs1data, 32'h0);
    @(negedge clk);
    wen = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_x4", rs1data, 32'h0);
    check("post_rst_x9", rs2data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24100005_register_file.md
Name: ysyx_24100005_register_file

Overview:
- Integer register file for the single-cycle RV32E/I core.
- 2^ADDR_WIDTH entries of DATA_WIDTH bits.
- Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- Entry 0 is hardwired to zero.
- Sits between the decoder (addresses from inst[19:15], inst[24:20], inst[11:7]) and the writeback mux.

Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2^ADDR_WIDTH (32).
- DATA_WIDTH, 32, register width in bits.

Ports:
- clk  input  1  clock; all writes on rising edge.
- rst  input  1  asynchronous, active-low reset; clears every entry while low.
- wen  input  1  write enable for the rd port.
- waddr  input  ADDR_WIDTH  write index (rd).
- wdata  input  DATA_WIDTH  write data.
- rs1addr  input  ADDR_WIDTH  read port 1 index.
- rs2addr  input  ADDR_WIDTH  read port 2 index.
- rs1data  output  DATA_WIDTH  read port 1 data.
- rs2data  output  DATA_WIDTH  read port 2 data.

Behaviour:
- Reset
  - rst low asynchronously forces all entries to 0, independent of clk.
  - rs1data/rs2data read 0 for any address while reset is held and after release until written.
  - Writes are ignored while rst is low.
  - Reset asserted on the same edge as a write: reset wins, entry stays 0.
- Write
  - On posedge clk with rst high, wen=1 and waddr!=0: entry[waddr] <= wdata.
  - wen=0: no entry changes.
- Entry 0
  - A write to waddr=0 is discarded.
  - Reads of index 0 always return 0.
- Read
  - Purely combinational. rsNdata = entry[rsNaddr], or 0 when rsNaddr=0.
  - Zero-cycle latency from address change.
- Read-during-write
  - Without bypass, a read of the same index being written returns the pre-edge value until the clock edge.
  - The new value is visible immediately after the edge.
- Ports are independent: rs1addr==rs2addr returns identical data on both.
- No X propagation from unwritten entries: all start at 0 via reset.
- No handshake and no internal state machine.

Optional Feature:
- Macro: YSYX_RF_BYPASS_EN.
- When defined:
  - Each read port forwards wdata combinationally when wen=1, rst high, waddr!=0 and rsNaddr==waddr.
  - Index 0 still reads 0.
- When undefined: reads return stored contents only, as described under Behaviour.

Decomposition:
- Shared package ysyx_24100005_rf_pkg holds:
  - RF_ADDR_W=5 and RF_DATA_W=32;
  - the zero-register index constant RF_ZERO_IDX=0;
  - typedefs rf_addr_t and rf_data_t.
- One natural sub-module, ysyx_24100005_rf_cell.
  - Parameterised WIDTH and RESET_VAL.
  - Ports clk, rst (active-low async), din, wen, dout.
  - Instantiated 2^ADDR_WIDTH-1 times via generate; entry 0 is a constant.
- Read selection is a key-indexed mux with default 0, one per read port.

Test Plan:
- Reset: hold rst=0 for 2 cycles with wen=1, waddr=5, wdata=0xDEADBEEF -> after release rs1addr=5 reads 0x00000000; sweeping all 32 indices reads 0.
- Basic write/read: write 0x12345678 to x1, then 0x80000000 to x31 -> rs1addr=1 gives 0x12345678, rs2addr=31 gives 0x80000000 in the same cycle.
- Zero register: wen=1, waddr=0, wdata=0xFFFFFFFF -> rs1addr=0 and rs2addr=0 both read 0x00000000 after the edge.
- wen gating: x7=0x0000000A, then wen=0, waddr=7, wdata=0x55 -> x7 remains 0x0000000A.
- Read-during-write: x3=0x11, then same cycle wen=1, waddr=3, wdata=0x22, rs1addr=3 -> before edge 0x11 (0x22 with YSYX_RF_BYPASS_EN); after edge 0x22.
- Async reset mid-operation: x9=0xCAFEBABE, drop rst between clock edges -> rs2addr=9 reads 0 immediately without waiting for clk.
